// File: rtl/matrix_scan_driver_pkg.sv
// Shared definitions for the 4x4 matrix path: geometry, scan states and the
// frame bit-ordering helper also used by the game-logic block.
package matrix_pkg;

    localparam int MATRIX_ROWS = 4;
    localparam int MATRIX_COLS = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Frame bit holding row r, column c.
    function automatic int cell_idx(input int r, input int c);
        return MATRIX_COLS * r + c;
    endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module scan_timer #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed 4x4 LED scan driver: latches a frame at the start of row 0,
// drives each row for DWELL_CYCLES with BLANK_CYCLES of dark time before it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BLANK | all rows/cols off, timing the gap before row row_idx
// ST_DRIVE | row drv select active, cols show that row's frame nibble
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] matrix,
    output logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic        frame_start
);

    localparam int CMAX     = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW       = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int BLANK_LD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CW-1:0] DWELL_VAL = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_VAL = CW'(BLANK_LD);
    localparam logic [3:0] ROWS_OFF = {4{ROW_ACTIVE_LOW}};
    localparam logic [3:0] COLS_OFF = {4{COL_ACTIVE_LOW}};

    scan_state_t    st, st_nxt;
    logic [1:0]     row_idx, drv_row;
    logic [15:0]    frame_buf, src;
    logic [3:0]     rows_nxt, cols_nxt, nib;
    logic           fs_nxt, tc, enter_drive, latch;
    logic [CW-1:0]  load_val;

    // The timer reloads on every terminal count with the length of the next state.
    assign load_val = (st_nxt == ST_DRIVE) ? DWELL_VAL : BLANK_VAL;

    scan_timer #(
        .W       (CW),
        .RST_VAL (BLANK_VAL)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tc),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= ST_BLANK;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_BLANK: if (tc) st_nxt = ST_DRIVE;
            ST_DRIVE: if (tc && BLANK_CYCLES != 0) st_nxt = ST_BLANK;
            default:  st_nxt = ST_BLANK;
        endcase
    end

    // With no blanking, a DRIVE terminal count moves directly into the next row.
    always_comb begin
        enter_drive = tc && (st == ST_BLANK || BLANK_CYCLES == 0);
        drv_row     = (st == ST_DRIVE) ? row_idx + 2'd1 : row_idx;
        latch       = enter_drive && (drv_row == 2'd0);
        src         = latch ? matrix : frame_buf;
        nib         = '0;
        for (int c = 0; c < MATRIX_COLS; c++)
            nib[c] = src[4'(cell_idx(int'(drv_row), c))] ^ COL_ACTIVE_LOW;
        rows_nxt = rows;
        cols_nxt = cols;
        fs_nxt   = 1'b0;
        if (enter_drive) begin
            rows_nxt = (4'b0001 << drv_row) ^ ROWS_OFF;
            cols_nxt = nib;
            fs_nxt   = latch;
        end else if (st == ST_DRIVE && tc) begin
            rows_nxt = ROWS_OFF;
            cols_nxt = COLS_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows        <= ROWS_OFF;
            cols        <= COLS_OFF;
            frame_start <= 1'b0;
            row_idx     <= 2'd0;
            frame_buf   <= 16'h0000;
        end else begin
            rows        <= rows_nxt;
            cols        <= cols_nxt;
            frame_start <= fs_nxt;
            if (latch)
                frame_buf <= matrix;
            if (st == ST_DRIVE && tc)
                row_idx <= row_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: three parameterisations checked every cycle
// against a frame-position model, plus vector table and corner sequences.
module tb_matrix_scan_driver;

    localparam int DA = 4, BA = 1; localparam bit RA = 1'b1, CA = 1'b0;
    localparam int DB = 4, BB = 0; localparam bit RB = 1'b1, CB = 1'b0;
    localparam int DC = 3, BC = 2; localparam bit RC = 1'b0, CC = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mat_a, mat_b, mat_c;
    logic [3:0]  rows_a, cols_a, rows_b, cols_b, rows_c, cols_c;
    logic        fs_a, fs_b, fs_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matrix_scan_driver #(.DWELL_CYCLES(DA), .BLANK_CYCLES(BA), .ROW_ACTIVE_LOW(RA), .COL_ACTIVE_LOW(CA))
        dut_a (.clk(clk), .rst_n(rst_n), .matrix(mat_a), .rows(rows_a), .cols(cols_a), .frame_start(fs_a));
    matrix_scan_driver #(.DWELL_CYCLES(DB), .BLANK_CYCLES(BB), .ROW_ACTIVE_LOW(RB), .COL_ACTIVE_LOW(CB))
        dut_b (.clk(clk), .rst_n(rst_n), .matrix(mat_b), .rows(rows_b), .cols(cols_b), .frame_start(fs_b));
    matrix_scan_driver #(.DWELL_CYCLES(DC), .BLANK_CYCLES(BC), .ROW_ACTIVE_LOW(RC), .COL_ACTIVE_LOW(CC))
        dut_c (.clk(clk), .rst_n(rst_n), .matrix(mat_c), .rows(rows_c), .cols(cols_c), .frame_start(fs_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Model: position k within the frame period decides everything.
    function automatic int offs(input int b);
        return (b == 0) ? 1 : 0;
    endfunction

    function automatic bit is_latch(input int d, input int b, input int k);
        if (k < offs(b)) return 1'b0;
        return ((k - offs(b)) % (4 * (b + d))) == b;
    endfunction

    function automatic logic [8:0] model(input int d, input int b, input bit ral, input bit cal,
                                         input int k, input logic [15:0] f);
        int phase, row, w;
        logic [3:0] sel;
        if (k < offs(b)) return {{4{ral}}, {4{cal}}, 1'b0};
        phase = (k - offs(b)) % (4 * (b + d));
        row   = phase / (b + d);
        w     = phase % (b + d);
        if (w < b) return {{4{ral}}, {4{cal}}, 1'b0};
        sel = 4'b0001 << row;
        return {(ral ? ~sel : sel), f[4*row +: 4] ^ {4{cal}}, (row == 0 && w == b)};
    endfunction

    task automatic mon_inst(input string nm, input int d, input int b, input bit ral, input bit cal,
                            input int k, input logic [15:0] m, inout logic [15:0] f,
                            input logic [3:0] r, input logic [3:0] c, input logic fs);
        if (is_latch(d, b, k)) f = m;
        check({nm, " outputs"}, {23'd0, r, c, fs}, {23'd0, model(d, b, ral, cal, k, f)});
    endtask

    bit rst_seen = 1'b0;
    always @(negedge rst_n) rst_seen = 1'b1;

    initial begin : monitor
        int k;
        bit r;
        logic [15:0] ma, mb, mc, fa, fb, fc;
        k = 0; fa = '0; fb = '0; fc = '0;
        forever begin
            @(posedge clk);
            r = rst_n; ma = mat_a; mb = mat_b; mc = mat_c;
            #1;
            if (!r) begin
                k = 0;
                rst_seen = 1'b0;
            end else if (rst_seen) begin
                k = 1;
                rst_seen = 1'b0;
            end else begin
                k++;
            end
            mon_inst("a", DA, BA, RA, CA, k, ma, fa, rows_a, cols_a, fs_a);
            mon_inst("b", DB, BB, RB, CB, k, mb, fb, rows_b, cols_b, fs_b);
            mon_inst("c", DC, BC, RC, CC, k, mc, fc, rows_c, cols_c, fs_c);
        end
    end

    task automatic wait_rows_a(input logic [3:0] pat, input string nm);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rows_a == pat) return;
        end
        timeout(nm);
    endtask

    task automatic wait_fs(input int inst, input string nm);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if ((inst == 0 && fs_a) || (inst == 1 && fs_b)) return;
        end
        timeout(nm);
    endtask

    typedef struct {
        logic [15:0] m;
        int          row;
        logic [3:0]  cols;
    } vec_t;

    vec_t vecs[12];
    int   n, bad;

    initial begin
        vecs[0]  = '{16'h8000, 3, 4'b1000};
        vecs[1]  = '{16'h8000, 0, 4'b0000};
        vecs[2]  = '{16'h8000, 1, 4'b0000};
        vecs[3]  = '{16'h8000, 2, 4'b0000};
        vecs[4]  = '{16'h1248, 0, 4'h8};
        vecs[5]  = '{16'h1248, 1, 4'h4};
        vecs[6]  = '{16'h1248, 2, 4'h2};
        vecs[7]  = '{16'h1248, 3, 4'h1};
        vecs[8]  = '{16'h000F, 0, 4'hF};
        vecs[9]  = '{16'hA5C3, 1, 4'hC};
        vecs[10] = '{16'hA5C3, 2, 4'h5};
        vecs[11] = '{16'hA5C3, 3, 4'hA};

        rst_n = 1'b0;
        mat_a = 16'hFFFF; mat_b = 16'hFFFF; mat_c = 16'hFFFF;
        repeat (5) @(posedge clk);
        #1;
        check("reset rows", {28'd0, rows_a}, 32'hF);
        check("reset cols", {28'd0, cols_a}, 32'h0);
        check("reset frame_start", {31'd0, fs_a}, 32'd0);
        #4 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            mat_a = vecs[i].m;
            wait_fs(0, "table frame_start");
            if (vecs[i].row != 0)
                wait_rows_a(~(4'b0001 << vecs[i].row), "table row");
            check($sformatf("table[%0d] cols", i), {28'd0, cols_a}, {28'd0, vecs[i].cols});
        end

        // Frame period on both blanking settings.
        wait_fs(0, "period a start");
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!fs_a && n < 100);
        check("period a", n, 20);
        mat_b = 16'h1248;
        wait_fs(1, "period b start");
        n = 0; bad = 0;
        do begin
            @(posedge clk); #1; n++;
            if (rows_b == 4'hF) bad++;
        end while (!fs_b && n < 100);
        check("period b", n, 16);
        check("b never blank", bad, 0);

        // Tearing: a change during row 1 must not reach row 3 of this frame.
        mat_a = 16'h000F;
        wait_fs(0, "tear latch");
        wait_rows_a(4'b1101, "tear row1");
        mat_a = 16'hF000;
        wait_rows_a(4'b0111, "tear row3");
        check("tear row3 old frame", {28'd0, cols_a}, 32'h0);
        wait_fs(0, "tear next frame");
        check("tear row0 new frame", {28'd0, cols_a}, 32'h0);
        wait_rows_a(4'b0111, "tear row3 next");
        check("tear row3 new frame", {28'd0, cols_a}, 32'hF);

        // Async reset pulse between edges during row 2.
        wait_rows_a(4'b1011, "areset row2");
        #2 rst_n = 1'b0;
        #1;
        check("areset rows a", {28'd0, rows_a}, 32'hF);
        check("areset cols a", {28'd0, cols_a}, 32'h0);
        check("areset rows c", {28'd0, rows_c}, 32'h0);
        check("areset cols c", {28'd0, cols_c}, 32'hF);
        mat_a = 16'h3C3C;
        #1 rst_n = 1'b1;
        #1 check("areset blank cycle", {28'd0, rows_a}, 32'hF);
        @(posedge clk); #1;
        check("areset row0 rows", {28'd0, rows_a}, 32'hE);
        check("areset row0 cols", {28'd0, cols_a}, 32'hC);
        check("areset frame_start", {31'd0, fs_a}, 32'd1);

        // Random frames on all instances; the monitor carries the checking.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(3) == 0) mat_a = 16'($urandom);
            if ($urandom_range(3) == 0) mat_b = 16'($urandom);
            if ($urandom_range(3) == 0) mat_c = 16'($urandom);
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(posedge clk); #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
